// File: rtl/lsu_pkg.sv
// Shared definitions for the memory-stage load/store unit: size codes, FSM states, helpers.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package lsu_pkg;

   localparam logic [1:0] SZ_WORD = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_BYTE = 2'b10;

   localparam int LSU_TIMEOUT_DEF = 255;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUS  = 2'b01,
      RESP = 2'b10
   } lsu_state_e;

   // Size code 11 behaves exactly like a word access.
   function automatic logic [1:0] lsu_norm_size(input logic [1:0] size);
      return (size == 2'b11) ? SZ_WORD : size;
   endfunction

   // Little-endian byte enables for a normalised size and low address bits.
   function automatic logic [3:0] lsu_byte_en(input logic [1:0] size, input logic [1:0] lo);
      case (size)
         SZ_BYTE: return 4'b0001 << lo;
         SZ_HALF: return lo[1] ? 4'b1100 : 4'b0011;
         default: return 4'b1111;
      endcase
   endfunction

endpackage

// File: rtl/lsu_mem_access_load_extend.sv
// Picks the addressed byte/half lane out of a bus read word and sign/zero-extends it.
// Latency: purely combinational.
// Backpressure: none; result is valid whenever the inputs are.
module lsu_load_extend
   import lsu_pkg::*;
(
   input  logic [31:0] i_rdata,
   input  logic [1:0]  i_addr_lo,
   input  logic [1:0]  i_size,
   input  logic        i_signed,
   output logic [31:0] o_data
);

   logic [7:0]  w_byte;
   logic [15:0] w_half;

   // Lane selection, then extension according to access size and signedness.
   always_comb begin
      w_byte = i_rdata[{i_addr_lo, 3'b000} +: 8];
      w_half = i_rdata[{i_addr_lo[1], 4'b0000} +: 16];
      o_data = i_rdata;
      case (i_size)
         SZ_BYTE: o_data = {{24{i_signed & w_byte[7]}}, w_byte};
         SZ_HALF: o_data = {{16{i_signed & w_half[15]}}, w_half};
         default: o_data = i_rdata;
      endcase
   end

endmodule

// File: rtl/lsu_mem_access.sv
// Memory-stage load/store unit driving a word-addressed req/ack data bus with byte enables.
// Latency: accept at edge N, bus_req in N+1, rsp_valid in N+2 with zero-wait ack (N+1 on a misalign trap).
// Backpressure: req_ready only in IDLE; bus_req held until bus_ack or watchdog; LSU_MISALIGN_TRAP_EN enables traps.
module lsu_mem_access
   import lsu_pkg::*;
#(
   parameter int TIMEOUT = LSU_TIMEOUT_DEF,
   parameter int CNT_W   = 8
)(
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        mem_read,
   input  logic        mem_write,
   input  logic [1:0]  inst_size,
   input  logic        is_signed,
   input  logic [31:0] addr,
   input  logic [31:0] wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic        rsp_misalign,
   output logic        busy,
   output logic        bus_req,
   output logic        bus_we,
   output logic [31:0] bus_addr,
   output logic [3:0]  bus_be,
   output logic [31:0] bus_wdata,
   input  logic        bus_ack,
   input  logic [31:0] bus_rdata
);

   localparam logic [CNT_W-1:0] LP_TMO   = CNT_W'(TIMEOUT);
   localparam bit               LP_WD_EN = (TIMEOUT != 0);

   lsu_state_e       r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [1:0]       r_size;
   logic [1:0]       r_addr_lo;
   logic             r_signed;
   logic             r_req_ready, r_busy, r_rsp_valid, r_rsp_err;
   logic [31:0]      r_rsp_rdata;
   logic             r_bus_req, r_bus_we;
   logic [31:0]      r_bus_addr, r_bus_wdata;
   logic [3:0]       r_bus_be;

   logic [1:0]       w_size;
   logic [1:0]       w_addr_lo;
   logic [3:0]       w_be;
   logic [31:0]      w_wdata;
   logic [31:0]      w_ld_data;
   logic             w_accept;

   // Decode the incoming op: normalised size, forced-aligned low bits, enables and replicated store data.
   always_comb begin
      w_size    = lsu_norm_size(inst_size);
      w_accept  = req_valid && (mem_read || mem_write);
      w_addr_lo = addr[1:0];
      w_wdata   = wdata;
      case (w_size)
         SZ_BYTE: w_wdata = {4{wdata[7:0]}};
         SZ_HALF: begin
            w_addr_lo = {addr[1], 1'b0};
            w_wdata   = {2{wdata[15:0]}};
         end
         default: w_addr_lo = 2'b00;
      endcase
      w_be = lsu_byte_en(w_size, w_addr_lo);
   end

`ifdef LSU_MISALIGN_TRAP_EN
   logic r_rsp_mis;
   logic w_misalign;

   // Unaligned half/word accesses are trapped instead of going to the bus.
   always_comb begin
      w_misalign = ((w_size == SZ_HALF) && addr[0]) ||
                   ((w_size == SZ_WORD) && (addr[1:0] != 2'b00));
   end

   assign rsp_misalign = r_rsp_mis;
`else
   assign rsp_misalign = 1'b0;
`endif

   lsu_load_extend u_load_extend (
      .i_rdata   (bus_rdata),
      .i_addr_lo (r_addr_lo),
      .i_size    (r_size),
      .i_signed  (r_signed),
      .o_data    (w_ld_data)
   );

   // Access FSM; every output is a register updated here.
   always_ff @(posedge clk) begin
      if (!reset) begin
         r_state     <= IDLE;
         r_cnt       <= '0;
         r_size      <= SZ_WORD;
         r_addr_lo   <= 2'b00;
         r_signed    <= 1'b0;
         r_req_ready <= 1'b1;
         r_busy      <= 1'b0;
         r_rsp_valid <= 1'b0;
         r_rsp_err   <= 1'b0;
         r_rsp_rdata <= '0;
         r_bus_req   <= 1'b0;
         r_bus_we    <= 1'b0;
         r_bus_addr  <= '0;
         r_bus_be    <= '0;
         r_bus_wdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
         r_rsp_mis   <= 1'b0;
`endif
      end else begin
         case (r_state)
            IDLE: begin
               if (w_accept) begin
                  r_size      <= w_size;
                  r_addr_lo   <= w_addr_lo;
                  r_signed    <= is_signed;
                  r_cnt       <= '0;
                  r_busy      <= 1'b1;
                  r_req_ready <= 1'b0;
`ifdef LSU_MISALIGN_TRAP_EN
                  if (w_misalign) begin
                     r_rsp_valid <= 1'b1;
                     r_rsp_err   <= 1'b1;
                     r_rsp_mis   <= 1'b1;
                     r_rsp_rdata <= '0;
                     r_state     <= RESP;
                  end else
`endif
                  begin
                     r_bus_req   <= 1'b1;
                     r_bus_we    <= mem_write;
                     r_bus_addr  <= {addr[31:2], 2'b00};
                     r_bus_be    <= w_be;
                     r_bus_wdata <= w_wdata;
                     r_state     <= BUS;
                  end
               end
            end
            BUS: begin
               // Ack has priority over the watchdog firing in the same cycle.
               if (bus_ack) begin
                  r_bus_req   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b0;
                  r_rsp_rdata <= r_bus_we ? 32'd0 : w_ld_data;
                  r_state     <= RESP;
               end else if (LP_WD_EN && (r_cnt == LP_TMO)) begin
                  r_bus_req   <= 1'b0;
                  r_rsp_valid <= 1'b1;
                  r_rsp_err   <= 1'b1;
                  r_rsp_rdata <= '0;
                  r_state     <= RESP;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            RESP: begin
               r_rsp_valid <= 1'b0;
               r_rsp_err   <= 1'b0;
               r_rsp_rdata <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
               r_rsp_mis   <= 1'b0;
`endif
               r_busy      <= 1'b0;
               r_req_ready <= 1'b1;
               r_state     <= IDLE;
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   assign req_ready = r_req_ready;
   assign busy      = r_busy;
   assign rsp_valid = r_rsp_valid;
   assign rsp_err   = r_rsp_err;
   assign rsp_rdata = r_rsp_rdata;
   assign bus_req   = r_bus_req;
   assign bus_we    = r_bus_we;
   assign bus_addr  = r_bus_addr;
   assign bus_be    = r_bus_be;
   assign bus_wdata = r_bus_wdata;

endmodule

// File: tb/tb_lsu_mem_access.sv
// Directed bench for lsu_mem_access with a short watchdog (TIMEOUT=4).
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: bus_ack driven by the bench; every wait is cycle-bounded.
module tb_lsu_mem_access;

   logic        clk = 1'b0;
   logic        reset;
   logic        req_valid, mem_read, mem_write, is_signed;
   logic [1:0]  inst_size;
   logic [31:0] addr, wdata;
   logic        req_ready, rsp_valid, rsp_err, rsp_misalign, busy;
   logic [31:0] rsp_rdata;
   logic        bus_req, bus_we, bus_ack;
   logic [31:0] bus_addr, bus_wdata, bus_rdata;
   logic [3:0]  bus_be;

   int n_tests = 0;
   int n_fail  = 0;

   always #5 clk = ~clk;

   lsu_mem_access #(.TIMEOUT(4), .CNT_W(8)) dut (
      .clk(clk), .reset(reset),
      .req_valid(req_valid), .req_ready(req_ready),
      .mem_read(mem_read), .mem_write(mem_write),
      .inst_size(inst_size), .is_signed(is_signed),
      .addr(addr), .wdata(wdata),
      .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_misalign(rsp_misalign), .busy(busy),
      .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
      .bus_be(bus_be), .bus_wdata(bus_wdata),
      .bus_ack(bus_ack), .bus_rdata(bus_rdata)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Present one op for a single edge; returns in the cycle after acceptance.
   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz,
                        input logic sg, input logic [31:0] a, input logic [31:0] wd);
      req_valid = 1'b1; mem_read = rd; mem_write = wr;
      inst_size = sz; is_signed = sg; addr = a; wdata = wd;
      step();
      req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
   endtask

   // Full access with zero-wait ack; checks bus side, response and return to idle.
   task automatic access(input string tag, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic sg,
                         input logic [31:0] a, input logic [31:0] wd, input logic [31:0] rdat,
                         input logic [31:0] exp_addr, input logic [3:0] exp_be,
                         input logic [31:0] exp_wd, input logic [31:0] exp_rsp);
      issue(rd, wr, sz, sg, a, wd);
      check({tag, ".bus_req"}, {31'd0, bus_req}, 32'd1);
      check({tag, ".bus_addr"}, bus_addr, exp_addr);
      check({tag, ".bus_be"}, {28'd0, bus_be}, {28'd0, exp_be});
      check({tag, ".bus_we"}, {31'd0, bus_we}, {31'd0, wr});
      if (wr) check({tag, ".bus_wdata"}, bus_wdata, exp_wd);
      bus_ack = 1'b1; bus_rdata = rdat;
      step();
      bus_ack = 1'b0; bus_rdata = 32'h0;
      check({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
      check({tag, ".rsp_rdata"}, rsp_rdata, exp_rsp);
      check({tag, ".rsp_err"}, {31'd0, rsp_err}, 32'd0);
      check({tag, ".rsp_mis"}, {31'd0, rsp_misalign}, 32'd0);
      step();
      check({tag, ".rsp_drop"}, {31'd0, rsp_valid}, 32'd0);
      check({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
   endtask

   initial begin
      int n;
      logic seen;
      reset = 1'b0; req_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
      inst_size = 2'b00; is_signed = 1'b0; addr = '0; wdata = '0;
      bus_ack = 1'b0; bus_rdata = '0;
      step(); step();
      check("rst.req_ready", {31'd0, req_ready}, 32'd1);
      check("rst.busy", {31'd0, busy}, 32'd0);
      check("rst.bus_req", {31'd0, bus_req}, 32'd0);
      check("rst.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("rst.bus_be", {28'd0, bus_be}, 32'd0);
      reset = 1'b1;
      step();

      // LB signed from top byte: stall flags while on the bus
      issue(1'b1, 1'b0, 2'b10, 1'b1, 32'h0000_1003, 32'h0);
      check("lb.busy", {31'd0, busy}, 32'd1);
      check("lb.req_ready", {31'd0, req_ready}, 32'd0);
      check("lb.bus_be", {28'd0, bus_be}, 32'h8);
      check("lb.bus_addr", bus_addr, 32'h0000_1000);
      bus_ack = 1'b1; bus_rdata = 32'h8000_0000;
      step();
      bus_ack = 1'b0;
      check("lb.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("lb.rsp_rdata", rsp_rdata, 32'hFFFF_FF80);
      step();
      check("lb.rsp_drop", {31'd0, rsp_valid}, 32'd0);

      //     tag      rd    wr    size   sgn   addr          wdata         bus_rdata     exp_addr      be       exp_wdata     exp_rsp
      access("lhu",  1'b1, 1'b0, 2'b01, 1'b0, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 32'h0000_2000, 4'b1100, 32'h0,        32'h0000_BEEF);
      access("lh",   1'b1, 1'b0, 2'b01, 1'b1, 32'h0000_2002, 32'h0,        32'hBEEF_1234, 32'h0000_2000, 4'b1100, 32'h0,        32'hFFFF_BEEF);
      access("sb",   1'b0, 1'b1, 2'b10, 1'b0, 32'h0000_0041, 32'h0000_00A5, 32'h1111_1111, 32'h0000_0040, 4'b0010, 32'hA5A5_A5A5, 32'h0);
      access("sh",   1'b0, 1'b1, 2'b01, 1'b0, 32'h0000_0082, 32'h1234_ABCD, 32'h0,        32'h0000_0080, 4'b1100, 32'hABCD_ABCD, 32'h0);
      access("lw",   1'b1, 1'b0, 2'b00, 1'b1, 32'h0000_0010, 32'h0,        32'hDEAD_BEEF, 32'h0000_0010, 4'b1111, 32'h0,        32'hDEAD_BEEF);
      access("lbu",  1'b1, 1'b0, 2'b10, 1'b0, 32'h0000_0021, 32'h0,        32'h0000_9A00, 32'h0000_0020, 4'b0010, 32'h0,        32'h0000_009A);
      access("sz11", 1'b1, 1'b0, 2'b11, 1'b1, 32'h0000_0030, 32'h0,        32'h8765_4321, 32'h0000_0030, 4'b1111, 32'h0,        32'h8765_4321);
      access("rdwr", 1'b1, 1'b1, 2'b00, 1'b0, 32'h0000_0044, 32'hCAFE_F00D, 32'h5555_5555, 32'h0000_0044, 4'b1111, 32'hCAFE_F00D, 32'h0);

      // valid with neither read nor write is ignored
      issue(1'b0, 1'b0, 2'b00, 1'b0, 32'h0000_0050, 32'h0);
      check("nop.busy", {31'd0, busy}, 32'd0);
      check("nop.bus_req", {31'd0, bus_req}, 32'd0);
      step();
      check("nop.rsp_valid", {31'd0, rsp_valid}, 32'd0);

      // watchdog: no ack, bus_req held for TIMEOUT+1 cycles
      issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0100, 32'h0);
      n = 0;
      while (bus_req && n < 20) begin
         n++;
         step();
      end
      check("tmo.req_cycles", n, 32'd5);
      check("tmo.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("tmo.rsp_err", {31'd0, rsp_err}, 32'd1);
      check("tmo.rsp_mis", {31'd0, rsp_misalign}, 32'd0);
      check("tmo.rsp_rdata", rsp_rdata, 32'h0);
      step();
      bus_ack = 1'b1; bus_rdata = 32'hFFFF_FFFF;
      step();
      bus_ack = 1'b0;
      check("stray.rsp_valid", {31'd0, rsp_valid}, 32'd0);
      check("stray.busy", {31'd0, busy}, 32'd0);

      // ack in the same cycle the watchdog would fire wins
      issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0200, 32'h0);
      for (int i = 0; i < 4; i++) step();
      check("race.bus_req", {31'd0, bus_req}, 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h0BAD_F00D;
      step();
      bus_ack = 1'b0;
      check("race.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("race.rsp_err", {31'd0, rsp_err}, 32'd0);
      check("race.rsp_rdata", rsp_rdata, 32'h0BAD_F00D);
      step();

      // reset during BUS abandons the access silently
      issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0300, 32'h0);
      reset = 1'b0;
      step();
      reset = 1'b1;
      check("rstmid.bus_req", {31'd0, bus_req}, 32'd0);
      check("rstmid.busy", {31'd0, busy}, 32'd0);
      check("rstmid.req_ready", {31'd0, req_ready}, 32'd1);
      bus_ack = 1'b1; bus_rdata = 32'h1234_5678;
      seen = 1'b0;
      for (int i = 0; i < 4; i++) begin
         if (rsp_valid) seen = 1'b1;
         step();
         bus_ack = 1'b0;
      end
      check("rstmid.no_rsp", {31'd0, seen}, 32'd0);

      // misaligned word at 0x06
`ifdef LSU_MISALIGN_TRAP_EN
      issue(1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0);
      check("mis.bus_req", {31'd0, bus_req}, 32'd0);
      check("mis.rsp_valid", {31'd0, rsp_valid}, 32'd1);
      check("mis.rsp_err", {31'd0, rsp_err}, 32'd1);
      check("mis.rsp_mis", {31'd0, rsp_misalign}, 32'd1);
      check("mis.rsp_rdata", rsp_rdata, 32'h0);
      step();
      check("mis.rsp_drop", {31'd0, rsp_valid}, 32'd0);
      check("mis.ready", {31'd0, req_ready}, 32'd1);
`else
      access("mis", 1'b1, 1'b0, 2'b00, 1'b0, 32'h0000_0006, 32'h0, 32'h1122_3344,
             32'h0000_0004, 4'b1111, 32'h0, 32'h1122_3344);
`endif

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/lsu_mem_access.md
Name: lsu_mem_access

Overview:
- Memory-stage load/store unit. Consumes the decoder's memory controls (mem_read, mem_write, inst_size, is_signed) plus the ALU address and rs2 data.
- Drives a 32-bit word-addressed data bus with byte enables, using a req/ack handshake.
- Returns sign- or zero-extended load data to writeback.
- Multi-cycle: holds the pipeline through `busy` until the bus access completes.

Parameters:
- TIMEOUT, 255, max cycles to wait for bus_ack before an error response; 0 disables the watchdog.
- CNT_W, 8, width of the timeout counter; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  reset, synchronous, active-low
- req_valid  in  1  memory op present this cycle
- req_ready  out  1  unit can accept an op (high only in IDLE)
- mem_read  in  1  load op
- mem_write  in  1  store op
- inst_size  in  2  00 WORD, 01 HALF, 10 BYTE, 11 treated as WORD
- is_signed  in  1  1 = sign-extend load, 0 = zero-extend
- addr  in  32  byte address
- wdata  in  32  store data (rs2)
- rsp_valid  out  1  one-cycle completion pulse
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  qualifies rsp_valid: timeout or misalign
- rsp_misalign  out  1  qualifies rsp_valid: misaligned access
- busy  out  1  state != IDLE; pipeline stall
- bus_req  out  1  bus request, held until ack
- bus_we  out  1  1 = write
- bus_addr  out  32  {addr[31:2], 2'b00}
- bus_be  out  4  byte enables, little-endian
- bus_wdata  out  32  lane-replicated store data
- bus_ack  in  1  bus completion, single cycle
- bus_rdata  in  32  read word, valid with bus_ack

Behaviour:
- Reset (reset==0 at an edge):
  - State returns to IDLE and the timeout counter clears.
  - All outputs go to 0, except req_ready=1.
  - Reset mid-access drops bus_req on the next edge. A late bus_ack is then ignored.
- FSM states: IDLE, BUS, RESP.
- IDLE:
  - Accept on req_valid && (mem_read || mem_write).
  - If both mem_read and mem_write are set, the op is a write.
  - req_valid with neither set is ignored; the unit stays in IDLE with no response.
  - On accept, register bus_addr, bus_be, bus_wdata and bus_we, plus the internal copies of size, signedness and addr[1:0]. Go to BUS.
- BUS:
  - bus_req=1 and all bus outputs are held stable.
  - If bus_ack is sampled high, capture the extended data and go to RESP.
  - Otherwise the counter increments. When the counter reaches TIMEOUT (TIMEOUT≠0), go to RESP with rsp_err=1 and rdata=0.
  - If ack and timeout occur in the same cycle, ack wins.
- RESP: rsp_valid=1 for exactly one cycle, then IDLE. rsp_* outputs are 0 whenever rsp_valid=0.
- Latency: accept at edge N; bus_req is high in cycle N+1; zero-wait ack then gives rsp_valid in cycle N+2. Throughput is one op per 3 cycles minimum.
- Byte-enable generation:
  - BYTE: be = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - HALF: be = addr[1] ? 1100 : 0011; wdata = {2{wdata[15:0]}}.
  - WORD: be = 1111.
  - Writes use the same be values.
- Load extraction:
  - BYTE lane = bus_rdata[8*addr[1:0] +: 8].
  - HALF lane = bus_rdata[16*addr[1] +: 16].
  - Extend to 32 bits per is_signed. WORD passes through.
- bus_ack while not in BUS is ignored.

Optional Feature:
- Macro LSU_MISALIGN_TRAP_EN.
- Defined:
  - HALF with addr[0]=1, or WORD with addr[1:0]≠0, performs no bus access; bus_req is never asserted.
  - The FSM goes IDLE→RESP, so rsp_valid is high in cycle N+1 with rsp_err=1, rsp_misalign=1 and rdata=0.
- Undefined:
  - Low address bits are forced: HALF ignores addr[0]; WORD ignores addr[1:0].
  - rsp_misalign is tied to 0.

Decomposition:
- Package lsu_pkg holds:
  - size localparams SZ_WORD=2'b00, SZ_HALF=2'b01, SZ_BYTE=2'b10;
  - the state encodings IDLE/BUS/RESP;
  - TIMEOUT default.
- One combinational sub-module, lsu_load_extend: takes bus_rdata, addr[1:0], size and is_signed, and returns the 32-bit result.

Test Plan:
- LB, addr=0x1003, is_signed=1, bus_rdata=0x80_00_00_00, zero-wait ack → bus_be=1000, bus_addr=0x1000, rsp_rdata=0xFFFF_FF80, rsp_valid two cycles after accept.
- LHU, addr=0x2002, bus_rdata=0xBEEF_1234 → be=1100, rsp_rdata=0x0000_BEEF. Same access as LH gives 0xFFFF_BEEF.
- SB, addr=0x41, wdata=0x0000_00A5 → bus_we=1, be=0010, bus_wdata=0xA5A5_A5A5, rsp_rdata=0.
- LW with bus_ack never asserted, TIMEOUT=4 → bus_req high for exactly 5 cycles, then rsp_valid with rsp_err=1, rsp_misalign=0; a later stray bus_ack is ignored.
- LW in progress, reset driven low for one cycle during BUS → next cycle bus_req=0, busy=0, req_ready=1; no rsp_valid is ever produced for that access.
- LSU_MISALIGN_TRAP_EN defined, LW addr=0x06 → bus_req stays 0; rsp_valid the next cycle with rsp_err=1, rsp_misalign=1. Without the macro, the same access reads 0x04 with be=1111.
